riscv_csr_m_trap: RTL and testbench
===================================

RISCV_CSR_M_TRAP -- requirements
Module: riscv_csr_m_trap

Interface
REQ-001 SHALL have parameter XLEN, default 64, architectural register width; legal values 32 or 64.
REQ-002 SHALL have parameter C_EXT, default 1, compressed-ISA support; when 0, bit 1 of mepc and of the redirect PC is forced to 0.
REQ-003 SHALL have parameter VECTOR_CAUSES, default 16, number of interrupt causes honoured in vectored mode; power of two, 1..64.
REQ-004 SHALL have parameter MTVEC_INIT, default '0, XLEN-bit reset value of mtvec.
REQ-005 SHALL have ports: i_clk input 1 clock; i_rst input 1 asynchronous active-high reset.
REQ-006 SHALL have ports: i_csr_valid input 1 CSR request; i_csr_write input 1 (1=write, 0=read); i_csr_addr input 12 CSR number; i_csr_wdata input XLEN write data.
REQ-007 SHALL have ports: o_csr_ready output 1 response strobe; o_csr_rdata output XLEN read data; o_csr_error output 1 unmapped address.
REQ-008 SHALL have ports: i_trap_valid input 1; o_trap_ready output 1; i_trap_cause input XLEN (MSB = interrupt); i_trap_pc input XLEN; i_trap_tval input XLEN.
REQ-009 SHALL have ports: o_redirect_valid output 1; i_redirect_ready input 1; o_redirect_pc output XLEN.
REQ-010 SHALL have ports: o_mtvec_mode output 2; o_mtvec_base output XLEN-2.

Function
REQ-011 SHALL map mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343; any other address SHALL return rdata 0 and o_csr_error=1 with no state change.
REQ-012 SHALL answer every accepted CSR request with o_csr_ready high for exactly one cycle, one cycle after acceptance; read data is the register value before any same-request write.
REQ-013 SHALL accept CSR requests only in state IDLE with i_trap_valid low; otherwise the request is held off (o_csr_ready low) until both hold; requester keeps valid/addr/data stable.
REQ-014 mtvec.mode is WARL: writes of 0 (direct) or 1 (vectored) SHALL update; writes of 2 or 3 SHALL leave mode unchanged while base still updates.
REQ-015 mepc writes SHALL clear bit 0 (and bit 1 when C_EXT=0); mcause and mtval SHALL store all XLEN bits.
REQ-016 State machine IDLE, CAPTURE, REDIRECT; o_trap_ready=1 only in IDLE.
REQ-017 IDLE->CAPTURE on i_trap_valid&o_trap_ready; cause, pc, tval latched at that edge.
REQ-018 CAPTURE (one cycle): mepc<=pc (masked per REQ-015), mcause<=cause, mtval<=tval, redirect PC computed; then ->REDIRECT.
REQ-019 Redirect PC: direct mode, or vectored with exception (cause MSB=0): {base,2'b00}; vectored interrupt: {base,2'b00} + 4*(cause mod VECTOR_CAUSES), modulo 2^XLEN (wrap, no carry out).
REQ-020 REDIRECT: o_redirect_valid=1, o_redirect_pc stable; ->IDLE on i_redirect_ready; valid SHALL not drop before ready.
REQ-021 Trap/CSR latency: trap accept to o_redirect_valid is exactly 2 cycles.
REQ-022 Trap and CSR request in the same IDLE cycle: trap wins; CSR is served after return to IDLE and sees captured values.
REQ-023 A CSR write to mtvec completed in cycle N SHALL govern any trap accepted in cycle N+1 or later.
REQ-024 o_mtvec_mode/o_mtvec_base SHALL reflect the register directly (no extra latency).

Reset
REQ-025 On i_rst high (asynchronous, any state): state=IDLE; mtvec=MTVEC_INIT with mode legalised (2/3 -> 0); mepc, mcause, mtval, o_csr_rdata, o_redirect_pc = 0; o_csr_ready, o_csr_error, o_redirect_valid = 0.
REQ-026 Reset mid-trap (CAPTURE or REDIRECT) SHALL abandon the trap; no register retains partial capture.

Verification
REQ-027 XLEN=64, write mtvec 0x8000_0001, trap cause 0x8000_0000_0000_0007 pc 0x1000 -> redirect_pc 0x8000_001C two cycles later, mepc 0x1000.
REQ-028 Same mtvec, exception cause 2 tval 0xDEAD -> redirect_pc 0x8000_0000, mcause 2, mtval 0xDEAD.
REQ-029 Write mtvec 0x4000_0003 over 0x0 -> read returns 0x4000_0000 (mode kept 0); read 0x300 -> rdata 0, error 1.
REQ-030 Same-cycle trap and mepc read, redirect_ready held low 5 cycles -> redirect_valid held 5 cycles, CSR ready only after return to IDLE, read returns trap pc.
REQ-031 XLEN=32, C_EXT=0, mtvec 0xFFFF_FFFD, interrupt cause 3 -> redirect_pc 0x0000_0008 (wrap); write mepc 0x1237 -> reads 0x1234.
REQ-032 Assert i_rst during REDIRECT -> redirect_valid falls immediately, mepc/mcause/mtval read 0, o_trap_ready=1 after release.

Source files
------------

// File: rtl/riscv_csr_m_trap.sv
// riscv_csr_m_trap
//   Machine-mode trap CSRs (mtvec, mepc, mcause, mtval) with a small trap
//   sequencer that captures a trap and issues a redirect PC.
//
//   Parameters
//     XLEN          architectural register width (32 or 64)
//     C_EXT         compressed-ISA support; 0 forces bit 1 of mepc/redirect PC low
//     VECTOR_CAUSES interrupt causes honoured in vectored mode (power of two, 1..64)
//     MTVEC_INIT    reset value of mtvec (mode legalised: 2/3 become 0)
//
//   Ports
//     i_clk, i_rst                  clock, asynchronous active-high reset
//     i_csr_valid/write/addr/wdata  CSR request (held stable until o_csr_ready)
//     o_csr_ready/rdata/error       one-cycle response strobe, old value, unmapped flag
//     i_trap_valid/o_trap_ready     trap request handshake, cause/pc/tval payload
//     o_redirect_valid/i_redirect_ready/o_redirect_pc  redirect handshake
//     o_mtvec_mode/o_mtvec_base     live mtvec fields
//     o_dbg_state                   current sequencer state (IDLE=0, CAPTURE=1, REDIRECT=2)
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. Trap and redirect use plain valid/ready; valid is never withdrawn
//   before ready. A CSR request is accepted on an edge where i_csr_valid is high,
//   the sequencer is IDLE, i_trap_valid is low and no response is currently
//   being returned; the response (o_csr_ready) is a single-cycle strobe in the
//   following cycle, after which the requester may drop or change its request.
module riscv_csr_m_trap #(
   parameter int                XLEN          = 64,
   parameter int                C_EXT         = 1,
   parameter int                VECTOR_CAUSES = 16,
   parameter logic [XLEN-1:0]   MTVEC_INIT    = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_csr_valid,
   input  logic              i_csr_write,
   input  logic [11:0]       i_csr_addr,
   input  logic [XLEN-1:0]   i_csr_wdata,
   output logic              o_csr_ready,
   output logic [XLEN-1:0]   o_csr_rdata,
   output logic              o_csr_error,
   input  logic              i_trap_valid,
   output logic              o_trap_ready,
   input  logic [XLEN-1:0]   i_trap_cause,
   input  logic [XLEN-1:0]   i_trap_pc,
   input  logic [XLEN-1:0]   i_trap_tval,
   output logic              o_redirect_valid,
   input  logic              i_redirect_ready,
   output logic [XLEN-1:0]   o_redirect_pc,
   output logic [1:0]        o_mtvec_mode,
   output logic [XLEN-3:0]   o_mtvec_base,
   output logic [1:0]        o_dbg_state
);

   localparam logic [11:0] ADDR_MTVEC  = 12'h305;
   localparam logic [11:0] ADDR_MEPC   = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE = 12'h342;
   localparam logic [11:0] ADDR_MTVAL  = 12'h343;

   // Bit 0 of any PC is always clear; bit 1 too without compressed instructions.
   localparam logic [XLEN-1:0] PC_MASK  = (C_EXT != 0) ? ~XLEN'(1) : ~XLEN'(3);
   // cause mod VECTOR_CAUSES as a mask, since VECTOR_CAUSES is a power of two.
   localparam logic [XLEN-1:0] VEC_MASK = XLEN'(VECTOR_CAUSES - 1);
   localparam logic [1:0]      INIT_MODE = (MTVEC_INIT[1:0] == 2'd1) ? 2'd1 : 2'd0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   state_t            state;
   logic [XLEN-3:0]   mtvec_base;
   logic [1:0]        mtvec_mode;
   logic [XLEN-1:0]   mepc;
   logic [XLEN-1:0]   mcause;
   logic [XLEN-1:0]   mtval;
   logic [XLEN-1:0]   cap_cause;
   logic [XLEN-1:0]   cap_pc;
   logic [XLEN-1:0]   cap_tval;

   logic              csr_hit;
   logic [XLEN-1:0]   csr_rd;
   logic              csr_accept;
   logic [XLEN-1:0]   vec_base;
   logic [XLEN-1:0]   redirect_calc;

   assign o_trap_ready = (state == ST_IDLE);
   assign o_mtvec_mode = mtvec_mode;
   assign o_mtvec_base = mtvec_base;
   assign o_dbg_state  = state;

   // A pending trap always wins over a CSR request in the same IDLE cycle.
   // The !o_csr_ready term stops a held request from being taken twice.
   assign csr_accept = i_csr_valid && (state == ST_IDLE) && !i_trap_valid && !o_csr_ready;

   always_comb begin
      csr_hit = 1'b1;
      csr_rd  = '0;
      case (i_csr_addr)
         ADDR_MTVEC:  csr_rd = {mtvec_base, mtvec_mode};
         ADDR_MEPC:   csr_rd = mepc;
         ADDR_MCAUSE: csr_rd = mcause;
         ADDR_MTVAL:  csr_rd = mtval;
         default:     csr_hit = 1'b0;
      endcase
   end

   // Vectored interrupts jump to base + 4*(cause mod VECTOR_CAUSES); the add
   // wraps at XLEN bits. Exceptions and direct mode always use the base.
   always_comb begin
      vec_base      = {mtvec_base, 2'b00};
      redirect_calc = vec_base;
      if ((mtvec_mode == 2'd1) && cap_cause[XLEN-1]) begin
         redirect_calc = vec_base + ((cap_cause & VEC_MASK) << 2);
      end
      redirect_calc = redirect_calc & PC_MASK;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state            <= ST_IDLE;
         mtvec_base       <= MTVEC_INIT[XLEN-1:2];
         mtvec_mode       <= INIT_MODE;
         mepc             <= '0;
         mcause           <= '0;
         mtval            <= '0;
         cap_cause        <= '0;
         cap_pc           <= '0;
         cap_tval         <= '0;
         o_csr_ready      <= 1'b0;
         o_csr_rdata      <= '0;
         o_csr_error      <= 1'b0;
         o_redirect_valid <= 1'b0;
         o_redirect_pc    <= '0;
      end else begin
         o_csr_ready <= 1'b0;
         o_csr_error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_trap_valid) begin
                  cap_cause <= i_trap_cause;
                  cap_pc    <= i_trap_pc;
                  cap_tval  <= i_trap_tval;
                  state     <= ST_CAPTURE;
               end else if (csr_accept) begin
                  o_csr_ready <= 1'b1;
                  o_csr_rdata <= csr_rd;
                  o_csr_error <= !csr_hit;
                  if (i_csr_write) begin
                     case (i_csr_addr)
                        ADDR_MTVEC: begin
                           mtvec_base <= i_csr_wdata[XLEN-1:2];
                           // WARL: only direct (0) and vectored (1) are legal modes.
                           if (i_csr_wdata[1] == 1'b0) mtvec_mode <= i_csr_wdata[1:0];
                        end
                        ADDR_MEPC:   mepc   <= i_csr_wdata & PC_MASK;
                        ADDR_MCAUSE: mcause <= i_csr_wdata;
                        ADDR_MTVAL:  mtval  <= i_csr_wdata;
                        default: ;
                     endcase
                  end
               end
            end
            ST_CAPTURE: begin
               mepc             <= cap_pc & PC_MASK;
               mcause           <= cap_cause;
               mtval            <= cap_tval;
               o_redirect_pc    <= redirect_calc;
               o_redirect_valid <= 1'b1;
               state            <= ST_REDIRECT;
            end
            ST_REDIRECT: begin
               if (i_redirect_ready) begin
                  o_redirect_valid <= 1'b0;
                  state            <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_csr_m_trap.sv
// tb_riscv_csr_m_trap
//   Bench for riscv_csr_m_trap. Two instances share clock and reset:
//   d64 (XLEN=64, C_EXT=1, MTVEC_INIT=0x2003) and d32 (XLEN=32, C_EXT=0).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. CSR responses and redirect handshakes are compared
//   against expected-value queues by monitor processes.
module tb_riscv_csr_m_trap;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- d64 signals ----------------
   logic        csr_valid = 0, csr_write = 0;
   logic [11:0] csr_addr = '0;
   logic [63:0] csr_wdata = '0;
   logic        csr_ready, csr_error;
   logic [63:0] csr_rdata;
   logic        trap_valid = 0, trap_ready;
   logic [63:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
   logic        redirect_valid, redirect_ready = 0;
   logic [63:0] redirect_pc;
   logic [1:0]  mtvec_mode;
   logic [61:0] mtvec_base;
   logic [1:0]  dbg_state;

   // ---------------- d32 signals ----------------
   logic        s_csr_valid = 0, s_csr_write = 0;
   logic [11:0] s_csr_addr = '0;
   logic [31:0] s_csr_wdata = '0;
   logic        s_csr_ready, s_csr_error;
   logic [31:0] s_csr_rdata;
   logic        s_trap_valid = 0, s_trap_ready;
   logic [31:0] s_trap_cause = '0, s_trap_pc = '0, s_trap_tval = '0;
   logic        s_redirect_valid, s_redirect_ready = 0;
   logic [31:0] s_redirect_pc;
   logic [1:0]  s_mtvec_mode;
   logic [29:0] s_mtvec_base;
   logic [1:0]  s_dbg_state;

   riscv_csr_m_trap #(.XLEN(64), .C_EXT(1), .VECTOR_CAUSES(16), .MTVEC_INIT(64'h2003)) d64 (
      .i_clk(clk), .i_rst(rst),
      .i_csr_valid(csr_valid), .i_csr_write(csr_write), .i_csr_addr(csr_addr),
      .i_csr_wdata(csr_wdata), .o_csr_ready(csr_ready), .o_csr_rdata(csr_rdata),
      .o_csr_error(csr_error), .i_trap_valid(trap_valid), .o_trap_ready(trap_ready),
      .i_trap_cause(trap_cause), .i_trap_pc(trap_pc), .i_trap_tval(trap_tval),
      .o_redirect_valid(redirect_valid), .i_redirect_ready(redirect_ready),
      .o_redirect_pc(redirect_pc), .o_mtvec_mode(mtvec_mode), .o_mtvec_base(mtvec_base),
      .o_dbg_state(dbg_state)
   );

   riscv_csr_m_trap #(.XLEN(32), .C_EXT(0), .VECTOR_CAUSES(16), .MTVEC_INIT(32'h0)) d32 (
      .i_clk(clk), .i_rst(rst),
      .i_csr_valid(s_csr_valid), .i_csr_write(s_csr_write), .i_csr_addr(s_csr_addr),
      .i_csr_wdata(s_csr_wdata), .o_csr_ready(s_csr_ready), .o_csr_rdata(s_csr_rdata),
      .o_csr_error(s_csr_error), .i_trap_valid(s_trap_valid), .o_trap_ready(s_trap_ready),
      .i_trap_cause(s_trap_cause), .i_trap_pc(s_trap_pc), .i_trap_tval(s_trap_tval),
      .o_redirect_valid(s_redirect_valid), .i_redirect_ready(s_redirect_ready),
      .o_redirect_pc(s_redirect_pc), .o_mtvec_mode(s_mtvec_mode), .o_mtvec_base(s_mtvec_base),
      .o_dbg_state(s_dbg_state)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [64:0] exp_q[$];     // {error, rdata} for d64 CSR responses
   logic [63:0] redir_q[$];   // redirect PCs for d64 handshakes
   logic [32:0] s_exp_q[$];   // {error, rdata} for d32 CSR responses
   logic [64:0] mon_e;
   logic [63:0] mon_r;
   logic [32:0] mon_s;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (csr_ready) begin
            if (exp_q.size() == 0) check("csr_unexpected", 64'd1, 64'd0);
            else begin
               mon_e = exp_q.pop_front();
               check("csr_rdata", csr_rdata, mon_e[63:0]);
               check("csr_error", {63'd0, csr_error}, {63'd0, mon_e[64]});
            end
         end
         if (redirect_valid && redirect_ready) begin
            if (redir_q.size() == 0) check("redir_unexpected", 64'd1, 64'd0);
            else begin
               mon_r = redir_q.pop_front();
               check("redirect_pc", redirect_pc, mon_r);
            end
         end
         if (s_csr_ready) begin
            if (s_exp_q.size() == 0) check("s_csr_unexpected", 64'd1, 64'd0);
            else begin
               mon_s = s_exp_q.pop_front();
               check("s_csr_rdata", {32'd0, s_csr_rdata}, {32'd0, mon_s[31:0]});
               check("s_csr_error", {63'd0, s_csr_error}, {63'd0, mon_s[32]});
            end
         end
      end
   end

   // ---------------- driver tasks (called and return at posedge+1) ----------------
   task automatic csr64(input logic wr, input logic [11:0] addr, input logic [63:0] wd,
                        input logic err, input logic [63:0] rd);
      logic got;
      exp_q.push_back({err, rd});
      csr_valid = 1'b1; csr_write = wr; csr_addr = addr; csr_wdata = wd;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (csr_ready) got = 1'b1;
      end
      if (!got) begin
         check("csr_timeout", 64'd0, 64'd1);
         exp_q.delete();
      end
      @(posedge clk); #1;
      csr_valid = 1'b0; csr_write = 1'b0;
   endtask

   task automatic csr32(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic err, input logic [31:0] rd);
      logic got;
      s_exp_q.push_back({err, rd});
      s_csr_valid = 1'b1; s_csr_write = wr; s_csr_addr = addr; s_csr_wdata = wd;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (s_csr_ready) got = 1'b1;
      end
      if (!got) begin
         check("s_csr_timeout", 64'd0, 64'd1);
         s_exp_q.delete();
      end
      @(posedge clk); #1;
      s_csr_valid = 1'b0; s_csr_write = 1'b0;
   endtask

   // Full trap on d64: checks ready, 2-cycle latency, hold while ready is low, drop.
   task automatic trap64(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                         input logic [63:0] exp_pc, input int hold);
      redir_q.push_back(exp_pc);
      trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval;
      @(negedge clk);
      check("trap_ready_idle", {63'd0, trap_ready}, 64'd1);
      @(posedge clk); #1;
      trap_valid = 1'b0;
      @(negedge clk);
      check("redir_capture_low", {63'd0, redirect_valid}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("redir_latency", {63'd0, redirect_valid}, 64'd1);
      check("trap_ready_busy", {63'd0, trap_ready}, 64'd0);
      check("state_redirect", {62'd0, dbg_state}, 64'd2);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("redir_hold", {63'd0, redirect_valid}, 64'd1);
      end
      @(posedge clk); #1;
      redirect_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      @(negedge clk);
      check("redir_drop", {63'd0, redirect_valid}, 64'd0);
      check("trap_ready_back", {63'd0, trap_ready}, 64'd1);
      @(posedge clk); #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [63:0] wdata;
      logic        err;
      logic [63:0] rdata;
   } vec_t;

   vec_t vecs [0:20];

   function automatic vec_t mk(input logic wr, input logic [11:0] addr, input logic [63:0] wd,
                               input logic err, input logic [63:0] rd);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wd; v.err = err; v.rdata = rd;
      return v;
   endfunction

   // ---------------- main test ----------------
   initial begin
      logic got;
      vecs[0]  = mk(0, 12'h305, 64'h0,                   0, 64'h2000);
      vecs[1]  = mk(0, 12'h341, 64'h0,                   0, 64'h0);
      vecs[2]  = mk(0, 12'h342, 64'h0,                   0, 64'h0);
      vecs[3]  = mk(0, 12'h343, 64'h0,                   0, 64'h0);
      vecs[4]  = mk(0, 12'h300, 64'h0,                   1, 64'h0);
      vecs[5]  = mk(1, 12'h300, 64'hFFFF,                1, 64'h0);
      vecs[6]  = mk(1, 12'h305, 64'h0,                   0, 64'h2000);
      vecs[7]  = mk(1, 12'h305, 64'h4000_0003,           0, 64'h0);
      vecs[8]  = mk(0, 12'h305, 64'h0,                   0, 64'h4000_0000);
      vecs[9]  = mk(1, 12'h305, 64'h4000_0001,           0, 64'h4000_0000);
      vecs[10] = mk(1, 12'h305, 64'h4000_0002,           0, 64'h4000_0001);
      vecs[11] = mk(0, 12'h305, 64'h0,                   0, 64'h4000_0001);
      vecs[12] = mk(1, 12'h341, 64'h1237,                0, 64'h0);
      vecs[13] = mk(0, 12'h341, 64'h0,                   0, 64'h1236);
      vecs[14] = mk(1, 12'h342, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0);
      vecs[15] = mk(0, 12'h342, 64'h0,                   0, 64'hFFFF_FFFF_FFFF_FFFF);
      vecs[16] = mk(1, 12'h343, 64'h1234_5678_9ABC_DEF0, 0, 64'h0);
      vecs[17] = mk(0, 12'h343, 64'h0,                   0, 64'h1234_5678_9ABC_DEF0);
      vecs[18] = mk(1, 12'h305, 64'h8000_0001,           0, 64'h4000_0001);
      vecs[19] = mk(0, 12'h305, 64'h0,                   0, 64'h8000_0001);
      vecs[20] = mk(0, 12'h344, 64'h0,                   1, 64'h0);

      // Reset state
      #12;
      check("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
      check("rst_csr_ready", {63'd0, csr_ready}, 64'd0);
      check("rst_trap_ready", {63'd0, trap_ready}, 64'd1);
      check("rst_mtvec_mode", {62'd0, mtvec_mode}, 64'd0);
      check("rst_mtvec_base", {2'd0, mtvec_base}, 64'h800);
      check("rst_state", {62'd0, dbg_state}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Table-driven CSR accesses
      for (int i = 0; i <= 20; i++) begin
         csr64(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata);
      end
      check("mtvec_mode_live", {62'd0, mtvec_mode}, 64'd1);
      check("mtvec_base_live", {2'd0, mtvec_base}, 64'h2000_0000);

      // Vectored interrupt, cause 7
      trap64(64'h8000_0000_0000_0007, 64'h1000, 64'h0, 64'h8000_001C, 0);
      csr64(0, 12'h341, 64'h0, 0, 64'h1000);
      csr64(0, 12'h342, 64'h0, 0, 64'h8000_0000_0000_0007);
      csr64(0, 12'h343, 64'h0, 0, 64'h0);

      // Vectored interrupt, cause 19 folds to 3; held 2 extra cycles
      trap64(64'h8000_0000_0000_0013, 64'h1004, 64'h55, 64'h8000_000C, 2);

      // Exception in vectored mode uses base
      trap64(64'h2, 64'h2002, 64'hDEAD, 64'h8000_0000, 1);
      csr64(0, 12'h341, 64'h0, 0, 64'h2002);
      csr64(0, 12'h342, 64'h0, 0, 64'h2);
      csr64(0, 12'h343, 64'h0, 0, 64'hDEAD);

      // Same-cycle trap and mepc read; redirect_ready low for 5 cycles
      exp_q.push_back({1'b0, 64'h3000});
      redir_q.push_back(64'h8000_0000);
      csr_valid = 1'b1; csr_write = 1'b0; csr_addr = 12'h341;
      trap_valid = 1'b1; trap_cause = 64'h1; trap_pc = 64'h3000; trap_tval = 64'h0;
      @(posedge clk); #1;
      trap_valid = 1'b0;
      @(negedge clk);
      check("race_csr_held_capture", {63'd0, csr_ready}, 64'd0);
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("race_redir_hold", {63'd0, redirect_valid}, 64'd1);
         check("race_csr_held", {63'd0, csr_ready}, 64'd0);
         @(posedge clk); #1;
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      check("race_csr_held_hs", {63'd0, csr_ready}, 64'd0);
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
         @(negedge clk);
         if (csr_ready) got = 1'b1;
      end
      check("race_csr_served", {63'd0, got}, 64'd1);
      if (!got) exp_q.delete();
      @(posedge clk); #1;
      csr_valid = 1'b0;

      // mtvec write to direct mode governs the very next trap
      csr64(1, 12'h305, 64'h100, 0, 64'h8000_0001);
      trap64(64'h8000_0000_0000_0005, 64'h40, 64'h0, 64'h100, 0);

      // Reset during REDIRECT abandons the trap
      trap_valid = 1'b1; trap_cause = 64'h8000_0000_0000_0001; trap_pc = 64'h5554; trap_tval = 64'h77;
      @(posedge clk); #1;
      trap_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_redirect", {63'd0, redirect_valid}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_redirect", {63'd0, redirect_valid}, 64'd0);
      check("rst_async_pc", redirect_pc, 64'd0);
      check("rst_async_state", {62'd0, dbg_state}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_trap_ready", {63'd0, trap_ready}, 64'd1);
      @(posedge clk); #1;
      csr64(0, 12'h341, 64'h0, 0, 64'h0);
      csr64(0, 12'h342, 64'h0, 0, 64'h0);
      csr64(0, 12'h343, 64'h0, 0, 64'h0);
      csr64(0, 12'h305, 64'h0, 0, 64'h2000);

      // XLEN=32, C_EXT=0: vectored wrap and mepc bit-1 masking
      csr32(1, 12'h305, 32'hFFFF_FFFD, 0, 32'h0);
      check("s_mtvec_mode", {62'd0, s_mtvec_mode}, 64'd1);
      check("s_mtvec_base", {34'd0, s_mtvec_base}, 64'h3FFF_FFFF);
      s_trap_valid = 1'b1; s_trap_cause = 32'h8000_0003; s_trap_pc = 32'h1236; s_trap_tval = 32'h9;
      @(posedge clk); #1;
      s_trap_valid = 1'b0;
      @(negedge clk);
      check("s_redir_capture_low", {63'd0, s_redirect_valid}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("s_redir_latency", {63'd0, s_redirect_valid}, 64'd1);
      check("s_redirect_pc", {32'd0, s_redirect_pc}, 64'h8);
      s_redirect_ready = 1'b1;
      @(posedge clk); #1;
      s_redirect_ready = 1'b0;
      @(negedge clk);
      check("s_redir_drop", {63'd0, s_redirect_valid}, 64'd0);
      @(posedge clk); #1;
      csr32(0, 12'h341, 32'h0, 0, 32'h1234);
      csr32(0, 12'h343, 32'h0, 0, 32'h9);
      csr32(1, 12'h341, 32'h1237, 0, 32'h1234);
      csr32(1, 12'h341, 32'h1233, 0, 32'h1234);
      csr32(0, 12'h341, 32'h0, 0, 32'h1230);
      csr32(0, 12'h7C0, 32'h0, 1, 32'h0);

      // Anything still queued was never answered
      repeat (3) @(posedge clk);
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      check("redir_q_drained", 64'(redir_q.size()), 64'd0);
      check("s_exp_q_drained", 64'(s_exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
